dl_reset_ctrl: RTL



---
 rtl/dl_reset_ctrl_pkg.sv | 14 +
 rtl/dl_reset_ctrl_tracker.sv | 113 +++++++++++
 rtl/dl_reset_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/dl_reset_ctrl_pkg.sv
// Shared reset-controller types: reset FSM state encoding and slot index width helper.
package dl_reset_ctrl_pkg;

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } rst_state_t;

    // A single slot still needs a one-bit index.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dl_reset_ctrl_tracker.sv
// Download tracker: edge detect, slot latch, byte count, loaded flags, optional watchdog.
// Latency: flags and dl_done update on the edge that first samples dl_active low; no backpressure.
module dl_tracker
    import dl_reset_ctrl_pkg::*;
#(
    parameter int NSLOTS      = 4,
    parameter int IDX_W       = 8,
    parameter int MIN_BYTES   = 1,
    parameter int WDOG_CYCLES = 1 << 20
) (
    input  logic                      clk_sys,
    input  logic                      res_n,
    input  logic                      dl_active,
    input  logic [IDX_W-1:0]          dl_index,
    input  logic                      dl_wr,
    input  logic [NSLOTS-1:0]         unload_req,
    output logic [NSLOTS-1:0]         loaded,
    output logic                      dl_busy,
    output logic [slot_w(NSLOTS)-1:0] cur_slot,
    output logic                      dl_done,
    output logic [slot_w(NSLOTS)-1:0] dl_done_slot,
    output logic                      dl_abort
);

    localparam int SLOT_W = slot_w(NSLOTS);
    localparam int CNT_W  = (MIN_BYTES > 0) ? $clog2(MIN_BYTES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W:0]   IDX_LIM = (IDX_W + 1)'(NSLOTS);

    logic              active_q;
    logic              rise;
    logic              fall;
    logic              in_range;
    logic              enough;
    logic              wdog_fire;
    logic [CNT_W-1:0]  byte_cnt;
    logic [NSLOTS-1:0] loaded_n;

    assign rise     = dl_active & ~active_q;
    assign fall     = ~dl_active & active_q;
    assign in_range = {1'b0, dl_index} < IDX_LIM;
    assign enough   = byte_cnt >= CNT_MIN;

`ifdef DLRC_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] idle_cnt;

    assign wdog_fire = dl_busy & ~dl_wr & ~fall & (idle_cnt == WD_LAST);

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            idle_cnt <= '0;
        end else if (rise || dl_wr || !dl_busy) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // Constant false for any legal limit; the limit only matters with the watchdog built in.
    assign wdog_fire = (WDOG_CYCLES < 0);
`endif

    // Unload requests are applied last so they win over a same-edge completion.
    always_comb begin
        loaded_n = loaded;
        if (rise && in_range) begin
            loaded_n[dl_index[SLOT_W-1:0]] = 1'b0;
        end
        if (fall && dl_busy && enough) begin
            loaded_n[cur_slot] = 1'b1;
        end
        loaded_n = loaded_n & ~unload_req;
    end

    // active_q resets high so a download already running at reset release is never tracked.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            active_q     <= 1'b1;
            loaded       <= '0;
            dl_busy      <= 1'b0;
            cur_slot     <= '0;
            byte_cnt     <= '0;
            dl_done      <= 1'b0;
            dl_done_slot <= '0;
            dl_abort     <= 1'b0;
        end else begin
            active_q <= dl_active;
            loaded   <= loaded_n;
            dl_done  <= 1'b0;
            dl_abort <= wdog_fire;
            if (rise && in_range) begin
                cur_slot <= dl_index[SLOT_W-1:0];
                byte_cnt <= '0;
                dl_busy  <= 1'b1;
            end else if (fall && dl_busy) begin
                dl_busy <= 1'b0;
                if (enough) begin
                    dl_done      <= 1'b1;
                    dl_done_slot <= cur_slot;
                end
            end else if (wdog_fire) begin
                dl_busy <= 1'b0;
            end else if (dl_busy && dl_wr && (byte_cnt != CNT_MAX)) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dl_reset_ctrl.sv
// Multi-slot download tracking plus stretched core reset; core_reset falls RST_HOLD cycles after the last cause.
// No backpressure; optional download watchdog under DLRC_WATCHDOG_EN.
module dl_reset_ctrl
    import dl_reset_ctrl_pkg::*;
#(
    parameter int                NSLOTS      = 4,
    parameter int                IDX_W       = 8,
    parameter logic [NSLOTS-1:0] REQ_MASK    = NSLOTS'(1),
    parameter logic [NSLOTS-1:0] HOLD_MASK   = NSLOTS'(1),
    parameter int                RST_HOLD    = 16,
    parameter int                MIN_BYTES   = 1,
    parameter int                WDOG_CYCLES = 1 << 20
) (
    input  logic                      clk_sys,
    input  logic                      res_n,
    input  logic                      dl_active,
    input  logic [IDX_W-1:0]          dl_index,
    input  logic                      dl_wr,
    input  logic                      rst_req,
    input  logic [NSLOTS-1:0]         unload_req,
    output logic [NSLOTS-1:0]         loaded,
    output logic                      core_reset,
    output logic                      dl_busy,
    output logic                      dl_done,
    output logic [slot_w(NSLOTS)-1:0] dl_done_slot,
    output logic                      dl_abort
);

    localparam int HC_W = $clog2(RST_HOLD);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(RST_HOLD - 1);

    rst_state_t                state;
    rst_state_t                state_n;
    logic [HC_W-1:0]           hold_cnt;
    logic [HC_W-1:0]           hold_cnt_n;
    logic [slot_w(NSLOTS)-1:0] cur_slot;
    logic                      cause;

    dl_tracker #(
        .NSLOTS      (NSLOTS),
        .IDX_W       (IDX_W),
        .MIN_BYTES   (MIN_BYTES),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_tracker (
        .clk_sys      (clk_sys),
        .res_n        (res_n),
        .dl_active    (dl_active),
        .dl_index     (dl_index),
        .dl_wr        (dl_wr),
        .unload_req   (unload_req),
        .loaded       (loaded),
        .dl_busy      (dl_busy),
        .cur_slot     (cur_slot),
        .dl_done      (dl_done),
        .dl_done_slot (dl_done_slot),
        .dl_abort     (dl_abort)
    );

    assign cause = rst_req
                 | (|unload_req)
                 | ((loaded & REQ_MASK) != REQ_MASK)
                 | (dl_busy & HOLD_MASK[cur_slot]);

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        case (state)
            S_HOLD: begin
                if (cause) begin
                    hold_cnt_n = '0;
                end else if (hold_cnt == HC_LAST) begin
                    state_n = S_RUN;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (cause) begin
                    state_n    = S_HOLD;
                    hold_cnt_n = '0;
                end
            end
            default: begin
                state_n    = S_HOLD;
                hold_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state      <= S_HOLD;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_cnt_n;
            core_reset <= (state_n == S_HOLD);
        end
    end

endmodule
